// File: rtl/switch_select_debounce.sv
// switch_select_debounce: 2-flop synchronisers and per-switch debounce FSMs feeding the demux selects.
// Define SELECT_CYCLE_EN for step mode (presses step a 2-bit select); default build is level mode.
module switch_select_debounce #(
   parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch_1,
   input  logic i_Switch_2,
   output logic o_Sel0,
   output logic o_Sel1,
   output logic o_Change
);

   localparam int unsigned   CW      = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

   typedef enum logic {STABLE, CHANGING} state_t;

   logic [1:0]    w_Pin;
   logic [1:0]    r_Sync1;
   logic [1:0]    r_Sync2;
   logic [1:0]    r_Level;
   logic [1:0]    w_Level_Next;
   state_t        r_State      [2];
   state_t        w_State_Next [2];
   logic [CW-1:0] r_Count      [2];
   logic [CW-1:0] w_Count_Next [2];
   logic [1:0]    r_Sel;
   logic [1:0]    w_Sel_Next;
   logic          r_Change;

   assign w_Pin = {i_Switch_2, i_Switch_1};

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Sync1 <= '0;
         r_Sync2 <= '0;
         r_Level <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            r_State[i] <= STABLE;
            r_Count[i] <= '0;
         end
      end else begin
         r_Sync1 <= w_Pin;
         r_Sync2 <= r_Sync1;
         r_Level <= w_Level_Next;
         for (int unsigned i = 0; i < 2; i++) begin
            r_State[i] <= w_State_Next[i];
            r_Count[i] <= w_Count_Next[i];
         end
      end
   end

   always_comb begin
      w_Level_Next = r_Level;
      for (int unsigned i = 0; i < 2; i++) begin
         w_State_Next[i] = r_State[i];
         w_Count_Next[i] = r_Count[i];
         case (r_State[i])
            STABLE: begin
               if (r_Sync2[i] != r_Level[i]) begin
                  w_State_Next[i] = CHANGING;
                  w_Count_Next[i] = '0;
               end
            end
            CHANGING: begin
               if (r_Sync2[i] == r_Level[i]) begin
                  w_State_Next[i] = STABLE;
                  w_Count_Next[i] = '0;
               end else if (r_Count[i] == CNT_MAX) begin
                  w_Level_Next[i] = r_Sync2[i];
                  w_State_Next[i] = STABLE;
                  w_Count_Next[i] = '0;
               end else begin
                  w_Count_Next[i] = r_Count[i] + 1'b1;
               end
            end
            default: begin
               w_State_Next[i] = STABLE;
               w_Count_Next[i] = '0;
            end
         endcase
      end
   end

`ifdef SELECT_CYCLE_EN
   // Press edges are taken from the next-level so the select moves in the acceptance cycle.
   logic [1:0] w_Rise;
   assign w_Rise = w_Level_Next & ~r_Level;

   always_comb begin
      w_Sel_Next = r_Sel;
      case (w_Rise)
         2'b01:   w_Sel_Next = r_Sel + 2'd1;
         2'b10:   w_Sel_Next = r_Sel - 2'd1;
         default: w_Sel_Next = r_Sel;
      endcase
   end
`else
   assign w_Sel_Next = w_Level_Next;
`endif

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Sel    <= '0;
         r_Change <= 1'b0;
      end else begin
         r_Sel    <= w_Sel_Next;
         r_Change <= (w_Sel_Next != r_Sel);
      end
   end

   assign o_Sel0   = r_Sel[0];
   assign o_Sel1   = r_Sel[1];
   assign o_Change = r_Change;

endmodule

// File: tb/tb_switch_select_debounce.sv
// Randomised and directed bench for switch_select_debounce against a run-length reference model.
// Honours SELECT_CYCLE_EN the same way as the design.
module tb_switch_select_debounce;

   localparam int unsigned LIMIT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sw1   = 1'b0;
   logic sw2   = 1'b0;
   logic sel0;
   logic sel1;
   logic chg;

   int n_checks = 0;
   int n_errors = 0;
   int n_pulse  = 0;

   always #5 clk = ~clk;

   switch_select_debounce #(.DEBOUNCE_LIMIT(LIMIT)) u_dut (
      .i_Clk      (clk),
      .i_Rst_L    (rst_n),
      .i_Switch_1 (sw1),
      .i_Switch_2 (sw2),
      .o_Sel0     (sel0),
      .o_Sel1     (sel1),
      .o_Change   (chg)
   );

   // Reference: pins are seen two edges late; a level is accepted once the
   // seen value has disagreed with it on LIMIT+1 consecutive edges.
   bit q0 [$];
   bit q1 [$];
   bit lvl  [2];
   bit s    [2];
   bit rise [2];
   int run  [2];
   int m_sel = 0;
   int nsel;
   bit m_chg = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0.delete(); q0.push_back(1'b0); q0.push_back(1'b0);
         q1.delete(); q1.push_back(1'b0); q1.push_back(1'b0);
         for (int i = 0; i < 2; i++) begin
            lvl[i] = 1'b0;
            run[i] = 0;
         end
         m_sel = 0;
         m_chg = 1'b0;
      end else begin
         s[0] = q0.pop_front(); q0.push_back(sw1);
         s[1] = q1.pop_front(); q1.push_back(sw2);
         for (int i = 0; i < 2; i++) begin
            rise[i] = 1'b0;
            run[i]  = (s[i] != lvl[i]) ? run[i] + 1 : 0;
            if (run[i] == int'(LIMIT) + 1) begin
               rise[i] = s[i];
               lvl[i]  = s[i];
               run[i]  = 0;
            end
         end
`ifdef SELECT_CYCLE_EN
         nsel = (m_sel + int'(rise[0]) - int'(rise[1]) + 4) % 4;
`else
         nsel = 2 * int'(lvl[1]) + int'(lvl[0]);
`endif
         m_chg = (nsel != m_sel);
         m_sel = nsel;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Check against the model at the falling edge, then drive the next pin values.
   task automatic cycle(input logic a, input logic b);
      @(negedge clk);
      chk("sel0", {31'b0, sel0}, m_sel & 1);
      chk("sel1", {31'b0, sel1}, (m_sel >> 1) & 1);
      chk("change", {31'b0, chg}, {31'b0, m_chg});
      if (chg === 1'b1) n_pulse++;
      sw1 = a;
      sw2 = b;
   endtask

   // Hold pins and report edges from the driving edge to each select bit going high.
   task automatic measure(input logic a, input logic b, output int l0, output int l1);
      l0 = -1;
      l1 = -1;
      for (int k = 1; k <= 20; k++) begin
         cycle(a, b);
         if (l0 < 0 && sel0 === 1'b1) l0 = k - 1;
         if (l1 < 0 && sel1 === 1'b1) l1 = k - 1;
      end
   endtask

   task automatic press(input logic a, input logic b);
      repeat (8) cycle(a, b);
      repeat (8) cycle(1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int l0;
      int l1;
      logic a;
      logic b;
`ifdef SELECT_CYCLE_EN
      int seq [5] = '{1, 2, 3, 0, 1};
`endif

      repeat (3) @(negedge clk);
      chk("rst_sel0", {31'b0, sel0}, 0);
      chk("rst_sel1", {31'b0, sel1}, 0);
      chk("rst_change", {31'b0, chg}, 0);
      rst_n = 1'b1;

      // Idle with both switches low
      n_pulse = 0;
      repeat (20) cycle(1'b0, 1'b0);
      chk("idle_pulses", n_pulse, 0);

`ifndef SELECT_CYCLE_EN
      // Clean rise of switch 1
      n_pulse = 0;
      cycle(1'b1, 1'b0);
      measure(1'b1, 1'b0, l0, l1);
      chk("clean_latency", l0, LIMIT + 2);
      chk("clean_pulses", n_pulse, 1);
      cycle(1'b0, 1'b0);
      repeat (12) cycle(1'b0, 1'b0);

      // Bounce 1,0,1,0 then held high
      n_pulse = 0;
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      measure(1'b1, 1'b0, l0, l1);
      chk("bounce_latency", l0, LIMIT + 2);
      chk("bounce_pulses", n_pulse, 1);
      cycle(1'b0, 1'b0);
      repeat (12) cycle(1'b0, 1'b0);

      // Both switches rise together
      n_pulse = 0;
      cycle(1'b1, 1'b1);
      measure(1'b1, 1'b1, l0, l1);
      chk("both_lat0", l0, LIMIT + 2);
      chk("both_lat1", l1, LIMIT + 2);
      chk("both_pulses", n_pulse, 1);

      // Reset in the middle of a debounce
      cycle(1'b0, 1'b1);
      repeat (12) cycle(1'b0, 1'b1);
      chk("pre_rst_sel1", {31'b0, sel1}, 1);
      cycle(1'b1, 1'b1);
      repeat (3) cycle(1'b1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_sel0", {31'b0, sel0}, 0);
      chk("async_sel1", {31'b0, sel1}, 0);
      chk("async_change", {31'b0, chg}, 0);
      repeat (2) cycle(1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      measure(1'b1, 1'b1, l0, l1);
      chk("rst_req_lat0", l0, LIMIT + 2);
      chk("rst_req_lat1", l1, LIMIT + 2);
      cycle(1'b0, 1'b0);
      repeat (12) cycle(1'b0, 1'b0);
`else
      // Step mode: presses walk the select, releases are ignored
      for (int p = 0; p < 5; p++) begin
         press(1'b1, 1'b0);
         chk("step_up", {30'b0, sel1, sel0}, seq[p]);
      end
      press(1'b0, 1'b1);
      chk("step_down", {30'b0, sel1, sel0}, 0);
      n_pulse = 0;
      press(1'b1, 1'b1);
      chk("step_both", {30'b0, sel1, sel0}, 0);
      chk("step_both_pulses", n_pulse, 0);
`endif

      // Random bouncy stimulus with one reset in the middle
      a = 1'b0;
      b = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 4) == 0) a = ~a;
         if ($urandom_range(0, 4) == 0) b = ~b;
         cycle(a, b);
         if (c == 200) begin
            rst_n = 1'b0;
            cycle(a, b);
            rst_n = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
